// File: rtl/ctrl_pipe.sv
// Carries the decoded control word through the EX/MEM/WB registers and generates load-use stall, branch flush and forwarding selects.
// Latency: one cycle per stage. Only ID->EX can stall; MEM and WB always advance. Optional perf counters: CTRL_PIPE_PERF_EN.
module ctrl_pipe #(
    parameter int CTRL_W = 13,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_branch_taken,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_wreg,
    output logic [REG_W-1:0]  mem_wreg,
    output logic [REG_W-1:0]  wb_wreg,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
`endif
);

    localparam int REGWRITE = CTRL_W - 1;
    localparam int REGDST_H = CTRL_W - 2;
    localparam int REGDST_L = CTRL_W - 3;
    localparam int MEMTOREG = CTRL_W - 8;

    logic             load_use;
    logic             flush;
    logic             load_ex;
    logic [REG_W-1:0] id_dest;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (mem_valid && mem_ctrl[REGWRITE] && (mem_wreg != '0) && (mem_wreg == src))
            return 2'b10;
        else if (wb_valid && wb_ctrl[REGWRITE] && (wb_wreg != '0) && (wb_wreg == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        load_use = id_valid && ex_valid && ex_ctrl[MEMTOREG] && ex_ctrl[REGWRITE]
                   && (ex_wreg != '0) && ((ex_wreg == id_rs) || (ex_wreg == id_rt));
        flush    = ex_valid && ex_branch_taken;
        // A taken branch squashes the ID instruction, so stalling it is pointless.
        stall_f  = load_use && !flush;
        stall_d  = load_use && !flush;
        flush_d  = flush;
        load_ex  = id_valid && !load_use && !flush;
        fwd_a    = fwd_sel(ex_rs);
        fwd_b    = fwd_sel(ex_rt);
    end

    always_comb begin
        id_dest = '0;
        case (id_ctrl[REGDST_H:REGDST_L])
            2'b00:   id_dest = id_rt;
            2'b01:   id_dest = id_rd;
            2'b10:   id_dest = '1;
            default: id_dest = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_wreg   <= '0;
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_wreg  <= '0;
            wb_valid  <= 1'b0;
            wb_ctrl   <= '0;
            wb_wreg   <= '0;
        end else begin
            if (load_ex) begin
                ex_valid <= 1'b1;
                ex_ctrl  <= id_ctrl;
                ex_rs    <= id_rs;
                ex_rt    <= id_rt;
                ex_wreg  <= id_dest;
            end else begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                ex_rs    <= '0;
                ex_rt    <= '0;
                ex_wreg  <= '0;
            end
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
            mem_wreg  <= ex_wreg;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            wb_wreg   <= mem_wreg;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (stall_f)  stall_cnt  <= stall_cnt + 1'b1;
            if (flush_d)  flush_cnt  <= flush_cnt + 1'b1;
            if (wb_valid) retire_cnt <= retire_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: a stage-list reference model predicts every cycle's outputs, a monitor compares them.
module tb_ctrl_pipe;

    localparam logic [12:0] RTYPE = 13'b1_01_0_0_0_0_0_0_0_0_10;
    localparam logic [12:0] LW    = 13'b1_00_1_0_0_0_1_0_0_0_00;
    localparam logic [12:0] BEQ   = 13'b0_00_0_1_0_0_0_0_0_0_01;
    localparam logic [12:0] JAL   = 13'b1_10_0_0_0_0_0_1_1_0_00;
    // Load-like word that is also a branch, so taken-branch and load-use can coincide.
    localparam logic [12:0] LDBR  = 13'b1_00_0_1_0_0_1_0_0_0_01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [12:0] id_ctrl = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        ex_branch_taken = 1'b0;
    logic        stall_f, stall_d, flush_d, ex_valid, mem_valid, wb_valid;
    logic [12:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic [1:0]  fwd_a, fwd_b;
`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;
`endif

    ctrl_pipe dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef CTRL_PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [12:0] c;
        logic [4:0]  rs, rt, wr;
    } stg_t;

    typedef struct packed {
        logic        sf, sd, fd, exv, memv, wbv;
        logic [12:0] exc, memc, wbc;
        logic [4:0]  exrs, exrt, exw, memw, wbw;
        logic [1:0]  fa, fb;
`ifdef CTRL_PIPE_PERF_EN
        logic [31:0] sc, fc, rc;
`endif
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    obs_t expq[$];

    stg_t m_ex = '0, m_mem = '0, m_wb = '0;
    stg_t n_ex = '0, n_mem = '0, n_wb = '0;
    logic [31:0] m_sc = '0, m_fc = '0, m_rc = '0;
    logic [31:0] n_sc = '0, n_fc = '0, n_rc = '0;
    logic        last_sd = 1'b0;

    always @(posedge clk) begin
        m_ex  <= n_ex;
        m_mem <= n_mem;
        m_wb  <= n_wb;
        m_sc  <= n_sc;
        m_fc  <= n_fc;
        m_rc  <= n_rc;
    end

    function automatic logic writes(input stg_t s, input logic [4:0] r);
        return s.v && s.c[12] && (s.wr != 5'd0) && (s.wr == r);
    endfunction

    function automatic logic [1:0] fwd_of(input stg_t mem, input stg_t wb, input logic [4:0] r);
        if (writes(mem, r)) return 2'b10;
        if (writes(wb, r))  return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [4:0] dest_of(input logic [12:0] c, input logic [4:0] rt, input logic [4:0] rd);
        case (c[11:10])
            2'b00:   return rt;
            2'b01:   return rd;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a = '{sf: stall_f, sd: stall_d, fd: flush_d, exv: ex_valid, memv: mem_valid, wbv: wb_valid,
              exc: ex_ctrl, memc: mem_ctrl, wbc: wb_ctrl, exrs: ex_rs, exrt: ex_rt,
              exw: ex_wreg, memw: mem_wreg, wbw: wb_wreg, fa: fwd_a, fb: fwd_b
`ifdef CTRL_PIPE_PERF_EN
              , sc: stall_cnt, fc: flush_cnt, rc: retire_cnt
`endif
              };
        return a;
    endfunction

    // Drive one cycle of ID inputs at the falling edge, predict outputs, queue the prediction.
    task automatic step(input logic r, input logic v, input logic [12:0] c,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic bt);
        stg_t ce, cm, cw;
        logic lu, fl;
        logic [31:0] csc, cfc, crc;
        obs_t e;
        @(negedge clk);
        reset = r; id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        ex_branch_taken = bt;
        #1;
        ce = r ? '0 : m_ex;
        cm = r ? '0 : m_mem;
        cw = r ? '0 : m_wb;
        csc = r ? '0 : m_sc;
        cfc = r ? '0 : m_fc;
        crc = r ? '0 : m_rc;
        fl = !r && ce.v && bt;
        lu = !r && v && ce.v && ce.c[12] && ce.c[5] && (ce.wr != 5'd0)
             && ((ce.wr == rs) || (ce.wr == rt));
        e = '{sf: lu && !fl, sd: lu && !fl, fd: fl, exv: ce.v, memv: cm.v, wbv: cw.v,
              exc: ce.c, memc: cm.c, wbc: cw.c, exrs: ce.rs, exrt: ce.rt,
              exw: ce.wr, memw: cm.wr, wbw: cw.wr,
              fa: fwd_of(cm, cw, ce.rs), fb: fwd_of(cm, cw, ce.rt)
`ifdef CTRL_PIPE_PERF_EN
              , sc: csc, fc: cfc, rc: crc
`endif
              };
        expq.push_back(e);
        last_sd = e.sd;
        if (r) begin
            n_ex = '0; n_mem = '0; n_wb = '0;
            n_sc = '0; n_fc = '0; n_rc = '0;
        end else begin
            n_wb  = cm;
            n_mem = ce;
            n_ex  = '0;
            if (v && !lu && !fl) begin
                n_ex.v  = 1'b1;
                n_ex.c  = c;
                n_ex.rs = rs;
                n_ex.rt = rt;
                n_ex.wr = dest_of(c, rt, rd);
            end
            n_sc = csc + {31'd0, e.sf};
            n_fc = cfc + {31'd0, fl};
            n_rc = crc + {31'd0, cw.v};
        end
        #3;
    endtask

    task automatic dchk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        #3;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got %h exp %h", $time, a, e);
            end
        end
    end

    task automatic nop(input logic bt);
        step(1'b0, 1'b0, 13'd0, 5'd0, 5'd0, 5'd0, bt);
    endtask

    initial begin
        logic [12:0] rc;
        logic [4:0]  rrs, rrt, rrd;
        logic        rv;
`ifdef CTRL_PIPE_PERF_EN
        logic [31:0] ret0;
`endif
        step(1'b1, 1'b1, RTYPE, 5'd1, 5'd2, 5'd3, 1'b1);
        dchk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        dchk("reset_flush_d", {31'd0, flush_d}, 32'd0);
        step(1'b1, 1'b0, 13'd0, 5'd0, 5'd0, 5'd0, 1'b0);

        // R-type producer with consumers at distance 1, 2 and 3
        step(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd3, 5'd4, 5'd5, 1'b0);
        nop(1'b0);
        dchk("fwd_dist1", {30'd0, fwd_a}, 32'b10);
        step(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
        nop(1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd3, 5'd4, 5'd6, 1'b0);
        nop(1'b0);
        dchk("fwd_dist2", {30'd0, fwd_a}, 32'b01);
        step(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
        nop(1'b0);
        nop(1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd3, 5'd4, 5'd7, 1'b0);
        nop(1'b0);
        dchk("fwd_dist3", {30'd0, fwd_a}, 32'b00);

        // Load-use: one stall cycle, then bubble, then WB forward
        step(1'b0, 1'b1, LW, 5'd9, 5'd8, 5'd0, 1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd8, 5'd10, 5'd11, 1'b0);
        dchk("lu_stall_f", {31'd0, stall_f}, 32'd1);
        dchk("lu_stall_d", {31'd0, stall_d}, 32'd1);
        step(1'b0, 1'b1, RTYPE, 5'd8, 5'd10, 5'd11, 1'b0);
        dchk("lu_one_cycle", {31'd0, stall_f}, 32'd0);
        dchk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        nop(1'b0);
        dchk("lu_ex_valid", {31'd0, ex_valid}, 32'd1);
        dchk("lu_fwd", {30'd0, fwd_a}, 32'b01);

        // Taken branch coinciding with load-use: flush wins
        step(1'b0, 1'b1, LDBR, 5'd9, 5'd8, 5'd0, 1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd8, 5'd10, 5'd11, 1'b1);
        dchk("prio_flush_d", {31'd0, flush_d}, 32'd1);
        dchk("prio_stall_f", {31'd0, stall_f}, 32'd0);
        step(1'b0, 1'b1, BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
        dchk("flush_bubble", {31'd0, ex_valid}, 32'd0);
        dchk("bt_gated", {31'd0, flush_d}, 32'd0);

        // Register 0 is never forwarded
        step(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd0, 5'd0, 5'd12, 1'b0);
        nop(1'b0);
        dchk("zero_fwd_a", {30'd0, fwd_a}, 32'b00);

        // JAL destination travels as 31
        step(1'b0, 1'b1, JAL, 5'd4, 5'd5, 5'd6, 1'b0);
        nop(1'b0);
        dchk("jal_ex", {27'd0, ex_wreg}, 32'd31);
        nop(1'b0);
        dchk("jal_mem", {27'd0, mem_wreg}, 32'd31);
        nop(1'b0);
        dchk("jal_wb", {27'd0, wb_wreg}, 32'd31);
`ifdef CTRL_PIPE_PERF_EN
        ret0 = retire_cnt;
        nop(1'b0);
        dchk("jal_retire", retire_cnt, ret0 + 32'd1);
`endif

        // Mid-run reset with all stages full
        step(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd3, 5'd3, 5'd4, 1'b0);
        step(1'b0, 1'b1, RTYPE, 5'd4, 5'd3, 5'd5, 1'b0);
        step(1'b1, 1'b1, RTYPE, 5'd5, 5'd4, 5'd6, 1'b0);
        dchk("mid_reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        dchk("mid_reset_mem_wreg", {27'd0, mem_wreg}, 32'd0);
        dchk("mid_reset_fwd_a", {30'd0, fwd_a}, 32'd0);

        // Random traffic; a stalled ID instruction is held, as the IF/ID register would
        rv = 1'b0; rc = '0; rrs = '0; rrt = '0; rrd = '0;
        for (int i = 0; i < 800; i++) begin
            if (!last_sd) begin
                rv = ($urandom_range(0, 5) != 0);
                case ($urandom_range(0, 4))
                    0: rc = RTYPE;
                    1: rc = LW;
                    2: rc = BEQ;
                    3: rc = JAL;
                    default: rc = 13'($urandom);
                endcase
                rrs = 5'($urandom_range(0, 7));
                rrt = 5'($urandom_range(0, 7));
                rrd = 5'($urandom_range(0, 7));
            end
            step($urandom_range(0, 99) == 0, rv, rc, rrs, rrt, rrd, $urandom_range(0, 3) == 0);
        end
        nop(1'b0);
        nop(1'b0);
        @(negedge clk);
        #4;
        dchk("scoreboard_drained", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer side of the main control decoder.
- Takes the decoded 13-bit control word from the ID stage and carries it, with destination-register info, through the EX, MEM and WB pipeline registers.
- Generates the load-use stall, the branch flush, and the EX-stage forwarding selects for the 5-stage pipeline.
- Sits between the ID-stage decoder outputs and the datapath stage registers/muxes.

Parameters:
- CTRL_W, 13: width of the packed control word.
- REG_W, 5: register index width.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_ctrl  in  CTRL_W  packed {regwrite, regdst[1:0], alusrc, branch, bne, memwrite, memtoreg, jump, jal, lb, aluop[1:0]}, MSB first.
- id_rs, id_rt, id_rd  in  REG_W  ID instruction register fields.
- ex_branch_taken  in  1  branch/bne resolved taken in EX.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID register.
- flush_d  out  1  clear IF/ID register.
- ex_valid, mem_valid, wb_valid  out  1  stage valid bits.
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W  stage control words.
- ex_rs, ex_rt  out  REG_W  EX source indices.
- ex_wreg, mem_wreg, wb_wreg  out  REG_W  resolved destination registers.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 MEM result, 01 WB result.

Behaviour:
- Reset: asynchronous and active-high; clk and reset are the only clock/reset.
  - While reset is high, all valid bits, ctrl words, ex_rs/ex_rt and wreg registers are 0 immediately.
  - stall_f, stall_d, flush_d and fwd_a/fwd_b are therefore 0 during reset.
  - Reset asserted mid-operation discards all in-flight instructions; no partial state survives.
- Destination resolution at the ID→EX capture, from regdst:
  - 00 → id_rt
  - 01 → id_rd
  - 10 → 31 (jal)
  - 11 → 0
- Stage registers: one cycle per stage, ID→EX→MEM→WB. The MEM and WB registers always advance; there is no back-pressure beyond EX.
- Load-use hazard, combinational. Asserted when all of the following hold:
  - id_valid and ex_valid are both 1
  - ex_ctrl.memtoreg and ex_ctrl.regwrite are both 1
  - ex_wreg != 0
  - ex_wreg == id_rs or ex_wreg == id_rt
- On a load-use hazard:
  - stall_f = stall_d = 1.
  - Next cycle the EX register loads a bubble: valid 0, ctrl 0, wreg 0, rs/rt 0.
  - Duration is exactly one cycle; the following cycle the load is in MEM and forwarding resolves the dependency.
- Branch flush: when ex_valid and ex_branch_taken are both 1:
  - flush_d = 1.
  - Next cycle EX loads a bubble, squashing the ID instruction.
- Gating:
  - ex_branch_taken is ignored when ex_valid = 0.
  - id_valid = 0 loads a bubble into EX.
- Simultaneous flush and load-use: flush wins; stall_f = stall_d = 0 and flush_d = 1.
- Forwarding for fwd_a (fwd_b identical using ex_rt):
  - 10 if mem_valid, mem_ctrl.regwrite, mem_wreg != 0 and mem_wreg == ex_rs.
  - Else 01 if the same conditions hold for the WB stage.
  - Else 00.
  - MEM has priority over WB.
  - Register 0 is never forwarded.
- Stored control words: bits are stored unmodified; the block does not reinterpret aluop, alusrc, jump or lb.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- Defined:
  - Adds outputs stall_cnt, flush_cnt and retire_cnt, each CNT_W wide.
  - Each counter increments on clock edges where, respectively, load-use stall is asserted, flush_d is asserted, or wb_valid is 1.
  - Counters wrap modulo 2^CNT_W and are cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run: fill all three stages with valid instructions, then pulse reset between clock edges → all valid, ctrl and wreg outputs read 0 before the next edge; stall_f, flush_d and fwd_a are 0.
- R-type forward:
  - Instruction 1: id_ctrl=13'b1_01_0_0_0_0_0_0_0_0_10, rd=3.
  - Instruction 2, next cycle: rs=3.
  - Expected: instruction 2 in EX sees fwd_a=10.
  - Repeat with the dependent instruction two slots later → fwd_a=01.
  - Dependent instruction three slots later → fwd_a=00.
- Load-use:
  - LW id_ctrl=13'b1_00_1_0_0_0_1_0_0_0_00, rt=8; next instruction rs=8.
  - Expected: stall_f = stall_d = 1 for exactly one cycle; the following cycle ex_valid=0.
  - Next cycle the dependent instruction is in EX with fwd_a=01.
- Branch flush priority:
  - BEQ in EX with ex_branch_taken=1 while the ID instruction also triggers load-use.
  - Expected: flush_d=1, stall_f=0; next cycle ex_valid=0.
  - ex_branch_taken=1 with ex_valid=0 → flush_d=0.
- Zero register: MEM stage writes reg 0 with regwrite=1 and ex_rs=0 → fwd_a=00.
- JAL destination: id_ctrl with regdst=10 and regwrite=1 → ex_wreg=31, then mem_wreg=31, then wb_wreg=31 on successive cycles.
  - With CTRL_PIPE_PERF_EN defined: retire_cnt increments by 1 when this instruction reaches WB.
